// File: rtl/arq_rx_if.sv
// Receive-side ARQ link bundle: frame strobe in, ack/nack back, plus the consumer's pop port.
// The slave modport faces the receiver FSM; master is the transmitter/consumer side.
interface arq_rx_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ERR_W      = 8
);
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_seq;
  logic                  rx_parity;
  logic                  rd_en;
  logic                  ack;
  logic                  nack;
  logic                  busy;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  empty;
  logic                  full;
  logic                  exp_seq;
  logic [ERR_W-1:0]      err_count;

  modport master (
    output rx_valid, rx_data, rx_seq, rx_parity, rd_en,
    input  ack, nack, busy, rd_data, rd_valid, empty, full, exp_seq, err_count
  );

  modport slave (
    input  rx_valid, rx_data, rx_seq, rx_parity, rd_en,
    output ack, nack, busy, rd_data, rd_valid, empty, full, exp_seq, err_count
  );
endinterface

// File: rtl/arq_rx_fsm.sv
// Stop-and-wait ARQ receiver: IDLE->CHECK->RESP per frame, ack/nack two cycles after the strobe.
// Frames arriving while busy are ignored; a full FIFO is signalled back to the sender with nack.
module arq_rx_fsm #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 4,
  parameter int ERR_W      = 8
) (
  input logic     clk,
  input logic     rst,
  arq_rx_if.slave bus
);
  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RESP} state_t;

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_seq, r_par;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [PW:0]           r_count;
  logic                  r_exp_seq;
  logic [ERR_W-1:0]      r_err;
  logic                  r_ack, r_nack;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;

  logic w_good, w_full, w_empty, w_pop;
  logic w_push, w_ack_nxt, w_nack_nxt, w_err_inc;

  assign w_good  = ~^{r_data, r_seq, r_par};
  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_pop   = bus.rd_en && !w_empty;

  // Decision order matters: parity first, then duplicate, then FIFO space.
  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = 1'b0;
    w_nack_nxt  = 1'b0;
    w_push      = 1'b0;
    w_err_inc   = 1'b0;
    case (r_state)
      S_IDLE: if (bus.rx_valid) w_state_nxt = S_CHECK;
      S_CHECK: begin
        w_state_nxt = S_RESP;
        if (!w_good) begin
          w_nack_nxt = 1'b1;
          w_err_inc  = 1'b1;
        end else if (r_seq != r_exp_seq) begin
          w_ack_nxt = 1'b1;
        end else if (w_full) begin
          w_nack_nxt = 1'b1;
        end else begin
          w_ack_nxt = 1'b1;
          w_push    = 1'b1;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_data     <= '0;
      r_seq      <= 1'b0;
      r_par      <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_exp_seq  <= 1'b0;
      r_err      <= '0;
      r_ack      <= 1'b0;
      r_nack     <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ack      <= w_ack_nxt;
      r_nack     <= w_nack_nxt;
      r_rd_valid <= w_pop;
      if (r_state == S_IDLE && bus.rx_valid) begin
        r_data <= bus.rx_data;
        r_seq  <= bus.rx_seq;
        r_par  <= bus.rx_parity;
      end
      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + 1'b1;
        r_exp_seq <= ~r_exp_seq;
      end
      if (w_err_inc && r_err != '1) r_err <= r_err + 1'b1;
      if (w_pop) begin
        r_rd_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr_ptr] <= r_data;
  end

  assign bus.ack       = r_ack;
  assign bus.nack      = r_nack;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.rd_data   = r_rd_data;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.exp_seq   = r_exp_seq;
  assign bus.err_count = r_err;
endmodule

// File: tb/tb_arq_rx_fsm.sv
// Bench for arq_rx_fsm: frame table plus hand sequences; popped words checked against a queue.
module tb_arq_rx_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic [3:0] sb_q[$];

  arq_rx_if #(.DATA_WIDTH(4), .ERR_W(8)) bus ();

  arq_rx_fsm #(.DATA_WIDTH(4), .DEPTH(4), .ERR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic       s;
    logic       p;
    logic       ack;
    logic       nack;
    logic       push;
    logic       eseq;
    logic [7:0] err;
    logic       emp;
    logic       ful;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic par_of(input logic [3:0] d, input logic s);
    return ^{d, s};
  endfunction

  task automatic send(input logic [3:0] d, input logic s, input logic p,
                      input logic eack, input logic enack, input logic push, input string nm);
    bus.rx_data   = d;
    bus.rx_seq    = s;
    bus.rx_parity = p;
    bus.rx_valid  = 1'b1;
    if (push) sb_q.push_back(d);
    tick();
    bus.rx_valid = 1'b0;
    check({nm, ".busy"}, 32'(bus.busy), 32'd1);
    tick();
    check({nm, ".ack"}, 32'(bus.ack), 32'(eack));
    check({nm, ".nack"}, 32'(bus.nack), 32'(enack));
    tick();
    check({nm, ".idle"}, 32'({bus.busy, bus.ack, bus.nack}), 32'd0);
  endtask

  task automatic pop(input logic exp_vld, input string nm);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check({nm, ".rd_valid"}, 32'(bus.rd_valid), 32'(exp_vld));
  endtask

  // Every popped word must be the oldest outstanding accepted frame.
  always @(negedge clk) begin
    if (!rst && bus.rd_valid) begin
      if (sb_q.size() == 0) check("sb.unexpected_pop", 32'(bus.rd_data), 32'hFFFF);
      else check("sb.rd_data", 32'(bus.rd_data), 32'(sb_q.pop_front()));
    end
    if (bus.ack && bus.nack) check("ack_nack_exclusive", 32'd1, 32'd0);
  end

  initial begin
    tbl[0] = '{4'hA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0};
    tbl[1] = '{4'hA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0};
    tbl[2] = '{4'h3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0};
    tbl[3] = '{4'h3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0};
    tbl[4] = '{4'h5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0};
    tbl[5] = '{4'h7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0};
    tbl[6] = '{4'h7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0};

    bus.rx_valid  = 1'b0;
    bus.rx_data   = '0;
    bus.rx_seq    = 1'b0;
    bus.rx_parity = 1'b0;
    bus.rd_en     = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    check("reset.outputs", 32'({bus.ack, bus.nack, bus.busy, bus.rd_valid, bus.full, bus.exp_seq}), 32'd0);
    check("reset.empty", 32'(bus.empty), 32'd1);
    check("reset.rd_data", 32'(bus.rd_data), 32'd0);
    check("reset.err_count", 32'(bus.err_count), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      send(tbl[i].d, tbl[i].s, tbl[i].p, tbl[i].ack, tbl[i].nack, tbl[i].push, $sformatf("row%0d", i));
      check($sformatf("row%0d.exp_seq", i), 32'(bus.exp_seq), 32'(tbl[i].eseq));
      check($sformatf("row%0d.err", i), 32'(bus.err_count), 32'(tbl[i].err));
      check($sformatf("row%0d.empty", i), 32'(bus.empty), 32'(tbl[i].emp));
      check($sformatf("row%0d.full", i), 32'(bus.full), 32'(tbl[i].ful));
    end
    pop(1'b1, "pop_a");
    pop(1'b1, "pop_3");
    check("drained.empty", 32'(bus.empty), 32'd1);

    pop(1'b0, "pop_empty");
    check("pop_empty.rd_data_hold", 32'(bus.rd_data), 32'h3);

    for (int i = 1; i <= 4; i++) begin
      logic [3:0] d;
      logic       s;
      d = 4'(i);
      s = ((i - 1) % 2) == 1;
      send(d, s, par_of(d, s), 1'b1, 1'b0, 1'b1, $sformatf("fill%0d", i));
    end
    check("fill.full", 32'(bus.full), 32'd1);
    send(4'h5, 1'b0, par_of(4'h5, 1'b0), 1'b0, 1'b1, 1'b0, "full_nack");
    check("full_nack.exp_seq", 32'(bus.exp_seq), 32'd0);
    check("full_nack.err", 32'(bus.err_count), 32'd3);
    pop(1'b1, "pop_1");
    check("pop_1.full", 32'(bus.full), 32'd0);
    send(4'h5, 1'b0, par_of(4'h5, 1'b0), 1'b1, 1'b0, 1'b1, "resend5");
    check("resend5.exp_seq", 32'(bus.exp_seq), 32'd1);
    check("resend5.full", 32'(bus.full), 32'd1);
    for (int i = 0; i < 4; i++) pop(1'b1, $sformatf("drain%0d", i));
    check("drain.empty", 32'(bus.empty), 32'd1);

    send(4'h6, 1'b1, par_of(4'h6, 1'b1), 1'b1, 1'b0, 1'b1, "f6");
    send(4'h7, 1'b0, par_of(4'h7, 1'b0), 1'b1, 1'b0, 1'b1, "f7");
    bus.rx_data   = 4'h8;
    bus.rx_seq    = 1'b1;
    bus.rx_parity = par_of(4'h8, 1'b1);
    bus.rx_valid  = 1'b1;
    sb_q.push_back(4'h8);
    tick();
    bus.rx_valid = 1'b0;
    bus.rd_en    = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("simul.ack", 32'(bus.ack), 32'd1);
    check("simul.rd_valid", 32'(bus.rd_valid), 32'd1);
    tick();
    pop(1'b1, "simul_pop7");
    check("simul.empty_after_one", 32'(bus.empty), 32'd0);
    pop(1'b1, "simul_pop8");
    check("simul.empty_after_two", 32'(bus.empty), 32'd1);
    pop(1'b0, "simul_pop_empty");

    for (int i = 0; i < 252; i++) send(4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "bad");
    check("sat.err_max", 32'(bus.err_count), 32'd255);
    send(4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "bad_sat");
    check("sat.err_hold", 32'(bus.err_count), 32'd255);
    check("sat.exp_seq", 32'(bus.exp_seq), 32'd0);

    send(4'h9, 1'b0, par_of(4'h9, 1'b0), 1'b1, 1'b0, 1'b1, "f9");
    check("f9.exp_seq", 32'(bus.exp_seq), 32'd1);
    bus.rx_data   = 4'hA;
    bus.rx_seq    = 1'b1;
    bus.rx_parity = par_of(4'hA, 1'b1);
    bus.rx_valid  = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("rst_check.ack_nack", 32'({bus.ack, bus.nack}), 32'd0);
    check("rst_check.busy", 32'(bus.busy), 32'd0);
    check("rst_check.exp_seq", 32'(bus.exp_seq), 32'd0);
    check("rst_check.err", 32'(bus.err_count), 32'd0);
    check("rst_check.empty", 32'(bus.empty), 32'd1);
    rst = 1'b0;
    sb_q.delete();
    tick();
    check("rst_check.no_late_resp", 32'({bus.ack, bus.nack, bus.busy}), 32'd0);
    tick();
    send(4'hC, 1'b0, par_of(4'hC, 1'b0), 1'b1, 1'b0, 1'b1, "post_rst");
    check("post_rst.exp_seq", 32'(bus.exp_seq), 32'd1);
    check("post_rst.empty", 32'(bus.empty), 32'd0);
    pop(1'b1, "pop_c");
    tick();
    check("sb.outstanding", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
